// File: rtl/alu_operand_stage_if.sv
// Handshake and writeback bundle between the decoder, the operand stage and the ALU.
// The slave view belongs to the stage; the master view belongs to whatever drives it.
interface alu_operand_stage_if #(
    parameter int AW = 3,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_ctrl;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [AW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [2:0]    out_ctrl;
    logic [AW-1:0] out_rd;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          illegal;

    modport slave (
        input  in_valid, in_ctrl, in_rs1, in_rs2, in_rd, out_ready, wb_en, wb_addr, wb_data,
        output in_ready, out_valid, out_a, out_b, out_ctrl, out_rd, illegal
    );

    modport master (
        output in_valid, in_ctrl, in_rs1, in_rs2, in_rd, out_ready, wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, out_a, out_b, out_ctrl, out_rd, illegal
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: register file, writeback bypass, pending-write
// scoreboard for RAW/WAW blocking, and one registered valid/ready output slot.
module alu_operand_stage #(
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS),
    parameter int DW    = 32
) (
    input logic                Clk,
    input logic                Reset,
    alu_operand_stage_if.slave bus
);
    localparam logic [2:0] CTRL_NOT = 3'b000;

    function automatic logic is_legal(input logic [2:0] code);
        return (code != 3'b110) && (code != 3'b111);
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic en, input logic [AW-1:0] idx);
        logic [NREGS-1:0] v;
        v = '0;
        if (en) v[idx] = 1'b1;
        return v;
    endfunction

    logic [DW-1:0]    regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] pend_eff;
    logic [NREGS-1:0] pend_next;
    logic             hazard;
    logic             in_ready_c;
    logic             accept;
    logic             issue;
    logic [DW-1:0]    opa;
    logic [DW-1:0]    opb;

    logic             vld_p1;
    logic [DW-1:0]    a_p1;
    logic [DW-1:0]    b_p1;
    logic [2:0]       ctrl_p1;
    logic [AW-1:0]    rd_p1;
    logic             illegal_p1;

    always_comb begin
        wb_mask    = onehot(bus.wb_en, bus.wb_addr);
        // A write retiring this cycle no longer blocks its readers or rewriters.
        pend_eff   = pending & ~wb_mask;
        hazard     = pend_eff[bus.in_rs1]
                   | ((bus.in_ctrl != CTRL_NOT) & pend_eff[bus.in_rs2])
                   | pend_eff[bus.in_rd];
        in_ready_c = (!vld_p1 | bus.out_ready) & !hazard;
        accept     = bus.in_valid & in_ready_c;
        issue      = accept & is_legal(bus.in_ctrl);

        opa = '0;
        if (bus.in_rs1 == '0)                                opa = '0;
        else if (bus.wb_en && (bus.wb_addr == bus.in_rs1))   opa = bus.wb_data;
        else                                                 opa = regs[bus.in_rs1];

        opb = '0;
        if (bus.in_rs2 == '0)                                opb = '0;
        else if (bus.wb_en && (bus.wb_addr == bus.in_rs2))   opb = bus.wb_data;
        else                                                 opb = regs[bus.in_rs2];

        // Set is ORed after the clear so a same-cycle issue to the retiring rd stays pending.
        pend_next = pend_eff | onehot(issue && (bus.in_rd != '0), bus.in_rd);
    end

    // Stage boundary: operand slot, register file and scoreboard
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            pending    <= '0;
            vld_p1     <= 1'b0;
            a_p1       <= '0;
            b_p1       <= '0;
            ctrl_p1    <= '0;
            rd_p1      <= '0;
            illegal_p1 <= 1'b0;
        end else begin
            if (bus.wb_en && (bus.wb_addr != '0)) regs[bus.wb_addr] <= bus.wb_data;
            pending    <= pend_next;
            illegal_p1 <= accept & !is_legal(bus.in_ctrl);
            if (issue) begin
                vld_p1  <= 1'b1;
                a_p1    <= opa;
                b_p1    <= opb;
                ctrl_p1 <= bus.in_ctrl;
                rd_p1   <= bus.in_rd;
            end else if (bus.out_ready) begin
                vld_p1  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = vld_p1;
    assign bus.out_a     = a_p1;
    assign bus.out_b     = b_p1;
    assign bus.out_ctrl  = ctrl_p1;
    assign bus.out_rd    = rd_p1;
    assign bus.illegal   = illegal_p1;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against an architectural model
// of the register file, pending set and output slot.
module tb_alu_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic last_rdy;

    alu_operand_stage_if #(.AW(3), .DW(32)) bus ();

    alu_operand_stage #(.NREGS(8), .AW(3), .DW(32)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] m_regs [8];
    bit          m_pend [8];
    bit          m_vld;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_ctrl, m_rd;
    bit          m_ill;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input bit [2:0] r, input bit we,
                                               input bit [2:0] wa, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && wa == r) return wd;
        return m_regs[r];
    endfunction

    task automatic step(input bit v, input bit [2:0] c, input bit [2:0] r1, input bit [2:0] r2,
                        input bit [2:0] rd, input bit ordy, input bit we, input bit [2:0] wa,
                        input logic [31:0] wd);
        bit          pe [8];
        bit          rdy, acc;
        logic [31:0] oa, ob;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_rs1    = r1;
        bus.in_rs2    = r2;
        bus.in_rd     = rd;
        bus.out_ready = ordy;
        bus.wb_en     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        #1;
        for (int i = 0; i < 8; i++) pe[i] = m_pend[i] && !(we && wa == 3'(i));
        rdy = !(pe[r1] || (c != 0 && pe[r2]) || pe[rd]) && (!m_vld || ordy);
        last_rdy = bus.in_ready;
        if (rst_n) check("in_ready", {31'b0, bus.in_ready}, {31'b0, rdy});
        acc = v && rdy;
        oa = model_read(r1, we, wa, wd);
        ob = model_read(r2, we, wa, wd);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
            m_vld = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_ill = 0;
        end else begin
            if (we && wa != 0) m_regs[wa] = wd;
            for (int i = 0; i < 8; i++) m_pend[i] = pe[i];
            m_ill = acc && (c >= 3'd6);
            if (acc && c < 3'd6) begin
                m_vld = 1; m_a = oa; m_b = ob; m_ctrl = c; m_rd = rd;
                if (rd != 0) m_pend[rd] = 1;
            end else if (ordy) begin
                m_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_vld});
        check("out_a", bus.out_a, m_a);
        check("out_b", bus.out_b, m_b);
        check("out_ctrl", {29'b0, bus.out_ctrl}, {29'b0, m_ctrl});
        check("out_rd", {29'b0, bus.out_rd}, {29'b0, m_rd});
        check("illegal", {31'b0, bus.illegal}, {31'b0, m_ill});
    endtask

    task automatic idle(input bit ordy);
        step(0, 3'd0, 3'd0, 3'd0, 3'd0, ordy, 0, 3'd0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
        m_vld = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_ill = 0;
        bus.in_valid = 0; bus.in_ctrl = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_rd = 0;
        bus.out_ready = 0; bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;

        rst_n = 0;
        idle(1);
        idle(1);
        check("rst_valid", {31'b0, bus.out_valid}, 32'h0);
        check("rst_a", bus.out_a, 32'h0);
        rst_n = 1;

        // Basic ADD issue after writebacks
        step(0, 3'd0, 3'd0, 3'd0, 3'd0, 1, 1, 3'd3, 32'h5);
        step(0, 3'd0, 3'd0, 3'd0, 3'd0, 1, 1, 3'd4, 32'h7);
        step(1, 3'd4, 3'd3, 3'd4, 3'd5, 1, 0, 3'd0, 32'h0);
        check("t1_valid", {31'b0, bus.out_valid}, 32'h1);
        check("t1_a", bus.out_a, 32'h5);
        check("t1_b", bus.out_b, 32'h7);
        check("t1_ctrl", {29'b0, bus.out_ctrl}, 32'h4);

        // RAW stall on r5 until its writeback, which bypasses
        step(1, 3'd1, 3'd5, 3'd3, 3'd6, 1, 0, 3'd0, 32'h0);
        check("t2_stall0", {31'b0, last_rdy}, 32'h0);
        step(1, 3'd1, 3'd5, 3'd3, 3'd6, 1, 0, 3'd0, 32'h0);
        check("t2_stall1", {31'b0, last_rdy}, 32'h0);
        step(1, 3'd1, 3'd5, 3'd3, 3'd6, 1, 1, 3'd5, 32'hC);
        check("t2_rdy", {31'b0, last_rdy}, 32'h1);
        check("t2_bypass", bus.out_a, 32'hC);

        // Back-pressure holds the slot
        for (int k = 0; k < 5; k++) step(1, 3'd4, 3'd3, 3'd4, 3'd7, 0, 0, 3'd0, 32'h0);
        check("t3_hold_rdy", {31'b0, last_rdy}, 32'h0);
        check("t3_hold_a", bus.out_a, 32'hC);
        step(1, 3'd4, 3'd3, 3'd4, 3'd7, 1, 0, 3'd0, 32'h0);
        check("t3_rd", {29'b0, bus.out_rd}, 32'h7);
        check("t3_a", bus.out_a, 32'h5);

        // Illegal code is dropped and pulses illegal
        step(1, 3'd6, 3'd1, 3'd2, 3'd3, 1, 0, 3'd0, 32'h0);
        check("t4_illegal", {31'b0, bus.illegal}, 32'h1);
        check("t4_valid", {31'b0, bus.out_valid}, 32'h0);
        idle(1);
        check("t4_pulse", {31'b0, bus.illegal}, 32'h0);
        step(1, 3'd4, 3'd1, 3'd2, 3'd3, 1, 0, 3'd0, 32'h0);
        check("t4_no_pend", {31'b0, last_rdy}, 32'h1);
        step(1, 3'd4, 3'd6, 3'd1, 3'd1, 1, 0, 3'd0, 32'h0);
        check("t4_pend6", {31'b0, last_rdy}, 32'h0);

        // r0 stays zero; NOT ignores a pending rs2
        step(1, 3'd4, 3'd0, 3'd0, 3'd1, 1, 1, 3'd0, 32'hFFFF_FFFF);
        check("t5_r0", bus.out_a, 32'h0);
        step(1, 3'd0, 3'd4, 3'd6, 3'd2, 1, 0, 3'd0, 32'h0);
        check("t5_not_rdy", {31'b0, last_rdy}, 32'h1);
        check("t5_not_a", bus.out_a, 32'h7);

        // Reset mid-operation clears slot, pending set and registers
        step(1, 3'd4, 3'd4, 3'd4, 3'd5, 1, 0, 3'd0, 32'h0);
        rst_n = 0;
        idle(0);
        check("t6_valid", {31'b0, bus.out_valid}, 32'h0);
        rst_n = 1;
        for (int r = 1; r < 8; r++) begin
            step(1, 3'd4, 3'(r), 3'(r), 3'd0, 1, 0, 3'd0, 32'h0);
            check("t6_rdy", {31'b0, last_rdy}, 32'h1);
            check("t6_zero", bus.out_a, 32'h0);
        end

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 3'($urandom_range(0, 7)), $urandom);
            rst_n = 1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
